reset_sequencer: RTL and testbench
==================================

Name: reset_sequencer

Overview:
Parametrised reset generator that replaces the single-output reset block between the board NRST pin, the PLL lock signal and the design.
- Synchronises and debounces NRST; filters pll_lock.
- Releases NUM_STAGES reset outputs in order, spaced by a programmable delay, so the PLL, clock buffers, video and core logic leave reset one after another.
- Reports the cause of the last reset and counts lock-loss events.

Parameters:
NUM_STAGES, 4, number of sequenced reset outputs (1..16)
DEBOUNCE_CYCLES, 1024, consecutive stable cycles required to accept an NRST level change (>=2)
STAGE_DELAY, 256, cycles between successive stage releases (>=1)
LOCK_FILTER, 16, consecutive high cycles of synchronised pll_lock before lock counts as good (>=1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high power-on reset
NRST  in  1  board reset button, active low, asynchronous to clk
pll_lock  in  1  PLL lock indicator, asynchronous to clk
stage_reset  out  NUM_STAGES  active-high resets; bit 0 released first
all_released  out  1  high while every stage is out of reset
reset_cause  out  2  cause of the last reset: 0=POWER, 1=BUTTON, 2=LOCK
lock_lost_count  out  8  saturating count of lock-loss events

Behaviour:
- Single clock domain. reset is asynchronous, active-high.
- While reset is high: state=HOLD, stage_reset all 1, all_released=0, reset_cause=POWER, lock_lost_count=0, all counters 0, debounced button=pressed, lock_good=0.
- Synchronisers: NRST and pll_lock each pass through a 2-flop synchroniser. Synchroniser flops also reset asynchronously to the safe level (NRST=0, lock=0).
- Debounce:
  - The debounced state flips only after the synchronised NRST has held the opposite level for DEBOUNCE_CYCLES consecutive cycles.
  - Any glitch restarts the counter.
  - Press = debounced low.
- Lock filter:
  - lock_good rises after LOCK_FILTER consecutive synchronised-high cycles.
  - It falls on the first synchronised-low cycle (no filtering on loss).
- FSM states: HOLD, WAIT_LOCK, RELEASE, RUN.
  - HOLD: all stages asserted. When the debounced button is released, go to WAIT_LOCK.
  - WAIT_LOCK: all stages asserted. When lock_good=1, go to RELEASE with idx=0 and delay counter=0.
  - RELEASE:
    - The delay counter counts to STAGE_DELAY-1.
    - On terminal count, stage_reset[idx] is cleared, the counter reset, and idx incremented.
    - After clearing bit NUM_STAGES-1, go to RUN.
    - Stage k deasserts exactly (k+1)*STAGE_DELAY cycles after entering RELEASE.
  - RUN: all_released=1, registered, in the same cycle that the last stage bit clears.
- Events, evaluated in any state other than HOLD:
  - Debounced press: next state HOLD, reset_cause=BUTTON.
  - Otherwise, lock_good falling in RELEASE or RUN: next state WAIT_LOCK, reset_cause=LOCK, lock_lost_count increments and saturates at 255.
  - Press and lock loss in the same cycle: button wins and the count still increments.
  - Lock loss while in WAIT_LOCK (lock_good had not yet risen): no event.
- Reassertion: on any event, every stage_reset bit goes to 1 and all_released to 0 on the next clock edge, together. There is no sequenced reassertion.
- Latency from the NRST pin falling to stage_reset all 1: 2 sync + DEBOUNCE_CYCLES + 1 cycles.
- All outputs are registered. reset_cause and lock_lost_count hold their values across button/lock resets and clear only on reset.
- Counter widths are $clog2 of their terminal value plus 1. idx width is $clog2(NUM_STAGES)+1.

Decomposition:
- Package reset_seq_pkg: FSM state encoding (2 bits) and cause constants CAUSE_POWER/CAUSE_BUTTON/CAUSE_LOCK.
- Sub-module sync_filter:
  - 2-flop synchroniser plus consecutive-cycle counter.
  - Parameters CYCLES and SYMMETRIC. SYMMETRIC=1 filters both edges (NRST); SYMMETRIC=0 filters only rising edges (pll_lock).
  - Instantiated twice.

Test Plan:
All scenarios use NUM_STAGES=3, DEBOUNCE_CYCLES=4, STAGE_DELAY=8, LOCK_FILTER=4.
1. Power-up: reset high for 5 cycles, then low; NRST=1; pll_lock=1 from cycle 0 -> stage_reset=3'b111 until the debounce and lock filters complete; bits 0/1/2 clear exactly 8/16/24 cycles after RELEASE entry; all_released=1 with bit 2; reset_cause=0.
2. Lock loss in RUN: pll_lock low for 1 cycle -> stage_reset=3'b111 within 2 sync + 1 cycles; reset_cause=2; lock_lost_count=1; resequences once lock has been high for 4 synchronised cycles.
3. Button glitch: NRST low for 3 cycles in RUN -> no change. NRST low for 10 cycles -> reset_cause=1, all stages asserted, state held until NRST has been high for 4 cycles.
4. Simultaneous: debounced press and lock loss in the same cycle -> reset_cause=1, lock_lost_count incremented.
5. Mid-sequence: lock loss after bit 0 has cleared in RELEASE -> all bits 1 next cycle; a full re-sequence follows from stage 0.
6. Saturation: 300 lock-loss events -> lock_lost_count=255. Asserting reset mid-RUN -> immediate asynchronous return to all-1s and count=0.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// Shared types for the reset sequencer: FSM state encoding and reset-cause codes.
package reset_seq_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_HOLD      = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_RELEASE   = 2'd2,
    ST_RUN       = 2'd3
  } seq_state_e;

  // Cause of the most recent reset
  localparam logic [1:0] CAUSE_POWER  = 2'd0;
  localparam logic [1:0] CAUSE_BUTTON = 2'd1;
  localparam logic [1:0] CAUSE_LOCK   = 2'd2;

endpackage

// File: rtl/sync_filter.sv
// Two-flop synchroniser followed by a consecutive-cycle level filter.
//   clk, reset : clock, async active-high reset (flops reset to 0 = safe level)
//   din        : asynchronous input
//   level_c    : filtered level
// SYMMETRIC=1: both edges need CYCLES stable synchronised cycles (button debounce).
// SYMMETRIC=0: rising edge needs CYCLES high cycles, a low synchronised sample
//              drops level_c in the same cycle (lock filter).
module sync_filter #(
  parameter int unsigned CYCLES    = 16,
  parameter bit          SYMMETRIC = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level_c
);

  localparam int unsigned CNT_W = $clog2(CYCLES) + 1;

  logic             meta_q;
  logic             sync_q;
  logic             level_q;
  logic             level_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Filter next-state: count consecutive samples that disagree with the held level
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (SYMMETRIC) begin
      if (sync_q == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_W'(CYCLES - 1)) begin
        level_d = sync_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      if (!sync_q) begin
        level_d = 1'b0;
        cnt_d   = '0;
      end else if (!level_q) begin
        if (cnt_q == CNT_W'(CYCLES - 1)) begin
          level_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  // Synchroniser and filter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      meta_q  <= din;
      sync_q  <= meta_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  // Loss of an asymmetric input is reported on the first low synchronised sample
  assign level_c = SYMMETRIC ? level_q : (level_q & sync_q);

endmodule

// File: rtl/reset_sequencer.sv
// Sequenced reset generator: debounces NRST, filters pll_lock and releases
// NUM_STAGES resets one after another, STAGE_DELAY cycles apart.
//   clk, reset       : clock, async active-high power-on reset
//   NRST             : board reset button (active low, asynchronous)
//   pll_lock         : PLL lock indicator (asynchronous)
//   stage_reset      : active-high stage resets, bit 0 released first
//   all_released     : every stage out of reset
//   reset_cause      : last reset cause (POWER/BUTTON/LOCK)
//   lock_lost_count  : saturating count of lock-loss events
module reset_sequencer #(
  parameter int unsigned NUM_STAGES      = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1024,
  parameter int unsigned STAGE_DELAY     = 256,
  parameter int unsigned LOCK_FILTER     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  NRST,
  input  logic                  pll_lock,
  output logic [NUM_STAGES-1:0] stage_reset,
  output logic                  all_released,
  output logic [1:0]            reset_cause,
  output logic [7:0]            lock_lost_count
);

  import reset_seq_pkg::*;

  localparam int unsigned DLY_W = $clog2(STAGE_DELAY) + 1;
  localparam int unsigned IDX_W = $clog2(NUM_STAGES) + 1;

  seq_state_e            state_q;
  seq_state_e            state_d;
  logic [NUM_STAGES-1:0] stage_d;
  logic                  all_rel_d;
  logic [1:0]            cause_d;
  logic [7:0]            lost_d;
  logic [DLY_W-1:0]      dly_q;
  logic [DLY_W-1:0]      dly_d;
  logic [IDX_W-1:0]      idx_q;
  logic [IDX_W-1:0]      idx_d;

  logic btn_level;
  logic lock_good;
  logic press_c;
  logic lock_loss_c;

  // Button debounce (level high = released)
  sync_filter #(.CYCLES(DEBOUNCE_CYCLES), .SYMMETRIC(1'b1)) u_btn_filter (
    .clk     (clk),
    .reset   (reset),
    .din     (NRST),
    .level_c (btn_level)
  );

  // Lock qualification
  sync_filter #(.CYCLES(LOCK_FILTER), .SYMMETRIC(1'b0)) u_lock_filter (
    .clk     (clk),
    .reset   (reset),
    .din     (pll_lock),
    .level_c (lock_good)
  );

  // Next-state and output logic
  always_comb begin
    state_d   = state_q;
    stage_d   = stage_reset;
    all_rel_d = all_released;
    cause_d   = reset_cause;
    lost_d    = lock_lost_count;
    dly_d     = dly_q;
    idx_d     = idx_q;

    press_c     = ~btn_level;
    // Lock is known good on entry to RELEASE, so any low seen here is a falling edge
    lock_loss_c = ((state_q == ST_RELEASE) || (state_q == ST_RUN)) && !lock_good;

    case (state_q)
      ST_HOLD: begin
        stage_d   = '1;
        all_rel_d = 1'b0;
        if (!press_c) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        stage_d   = '1;
        all_rel_d = 1'b0;
        if (lock_good) begin
          state_d = ST_RELEASE;
          dly_d   = '0;
          idx_d   = '0;
        end
      end
      ST_RELEASE: begin
        if (dly_q == DLY_W'(STAGE_DELAY - 1)) begin
          dly_d = '0;
          idx_d = idx_q + IDX_W'(1);
          for (int unsigned k = 0; k < NUM_STAGES; k++) begin
            if (idx_q == IDX_W'(k)) stage_d[k] = 1'b0;
          end
          if (idx_q == IDX_W'(NUM_STAGES - 1)) begin
            state_d   = ST_RUN;
            all_rel_d = 1'b1;
          end
        end else begin
          dly_d = dly_q + DLY_W'(1);
        end
      end
      ST_RUN: begin
        all_rel_d = 1'b1;
      end
      default: begin
        state_d = ST_HOLD;
      end
    endcase

    // Events: button wins over lock loss, but a coincident loss is still counted
    if (state_q != ST_HOLD) begin
      if (lock_loss_c && (lock_lost_count != 8'hFF)) begin
        lost_d = lock_lost_count + 8'd1;
      end
      if (press_c) begin
        state_d   = ST_HOLD;
        cause_d   = CAUSE_BUTTON;
        stage_d   = '1;
        all_rel_d = 1'b0;
      end else if (lock_loss_c) begin
        state_d   = ST_WAIT_LOCK;
        cause_d   = CAUSE_LOCK;
        stage_d   = '1;
        all_rel_d = 1'b0;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_HOLD;
      stage_reset     <= '1;
      all_released    <= 1'b0;
      reset_cause     <= CAUSE_POWER;
      lock_lost_count <= 8'd0;
      dly_q           <= '0;
      idx_q           <= '0;
    end else begin
      state_q         <= state_d;
      stage_reset     <= stage_d;
      all_released    <= all_rel_d;
      reset_cause     <= cause_d;
      lock_lost_count <= lost_d;
      dly_q           <= dly_d;
      idx_q           <= idx_d;
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: stimulus pushes timestamped expected
// outputs, a negedge monitor pops and compares them.
module tb_reset_sequencer;

  localparam int unsigned NS = 3;
  localparam int unsigned DB = 4;
  localparam int unsigned SD = 8;
  localparam int unsigned LF = 4;

  logic          clk;
  logic          reset;
  logic          NRST;
  logic          pll_lock;
  logic [NS-1:0] stage_reset;
  logic          all_released;
  logic [1:0]    reset_cause;
  logic [7:0]    lock_lost_count;

  reset_sequencer #(
    .NUM_STAGES      (NS),
    .DEBOUNCE_CYCLES (DB),
    .STAGE_DELAY     (SD),
    .LOCK_FILTER     (LF)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .NRST            (NRST),
    .pll_lock        (pll_lock),
    .stage_reset     (stage_reset),
    .all_released    (all_released),
    .reset_cause     (reset_cause),
    .lock_lost_count (lock_lost_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned   at;
    string         tag;
    logic [NS-1:0] sr;
    logic          ar;
    logic [1:0]    cause;
    logic [7:0]    cnt;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_assert++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h (t=%0t)", tag, obs, want, $time);
    end
  endtask

  task automatic expect_at(input int unsigned at, input string tag, input logic [NS-1:0] sr,
                           input logic ar, input logic [1:0] cause, input logic [7:0] cnt);
    exp_t e;
    e.at = at; e.tag = tag; e.sr = sr; e.ar = ar; e.cause = cause; e.cnt = cnt;
    sb.push_back(e);
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int unsigned c);
    while (cyc < c) tick(1);
  endtask

  // Monitor: compare every expectation due at this cycle
  always @(negedge clk) begin
    while (sb.size() != 0 && sb[0].at <= cyc) begin
      mon_e = sb.pop_front();
      check({mon_e.tag, ".cycle"}, cyc, mon_e.at);
      check({mon_e.tag, ".stage_reset"}, 32'(stage_reset), 32'(mon_e.sr));
      check({mon_e.tag, ".all_released"}, 32'(all_released), 32'(mon_e.ar));
      check({mon_e.tag, ".reset_cause"}, 32'(reset_cause), 32'(mon_e.cause));
      check({mon_e.tag, ".lock_lost_count"}, 32'(lock_lost_count), 32'(mon_e.cnt));
    end
  end

  int unsigned t;
  int unsigned e;
  int          c;

  initial begin
    reset    = 1'b1;
    NRST     = 1'b1;
    pll_lock = 1'b1;

    // 1. Power-up: button accepted at 5+2+DB, WAIT_LOCK one edge later, RELEASE the next
    e = 5 + 2 + DB + 2;
    expect_at(2,          "por_in_reset", 3'b111, 1'b0, 2'd0, 8'd0);
    expect_at(e - 1,      "por_wait",     3'b111, 1'b0, 2'd0, 8'd0);
    expect_at(e + SD - 1, "por_b0_pre",   3'b111, 1'b0, 2'd0, 8'd0);
    expect_at(e + SD,     "por_b0",       3'b110, 1'b0, 2'd0, 8'd0);
    expect_at(e + 2*SD-1, "por_b1_pre",   3'b110, 1'b0, 2'd0, 8'd0);
    expect_at(e + 2*SD,   "por_b1",       3'b100, 1'b0, 2'd0, 8'd0);
    expect_at(e + 3*SD-1, "por_b2_pre",   3'b100, 1'b0, 2'd0, 8'd0);
    expect_at(e + 3*SD,   "por_run",      3'b000, 1'b1, 2'd0, 8'd0);
    tick(5);
    reset = 1'b0;
    wait_to(e + 3*SD + 3);

    // 2. One-cycle lock loss in RUN: reassert after 2 sync + 1, relock after LF more
    t = cyc;
    e = t + 8;
    expect_at(t + 2,      "lock_pre",     3'b000, 1'b1, 2'd0, 8'd0);
    expect_at(t + 3,      "lock_hit",     3'b111, 1'b0, 2'd2, 8'd1);
    expect_at(e - 1,      "lock_wait",    3'b111, 1'b0, 2'd2, 8'd1);
    expect_at(e + SD - 1, "lock_b0_pre",  3'b111, 1'b0, 2'd2, 8'd1);
    expect_at(e + SD,     "lock_b0",      3'b110, 1'b0, 2'd2, 8'd1);
    expect_at(e + 3*SD,   "lock_run",     3'b000, 1'b1, 2'd2, 8'd1);
    pll_lock = 1'b0;
    tick(1);
    pll_lock = 1'b1;
    wait_to(e + 3*SD + 3);

    // 3a. Short button glitch is ignored
    t = cyc;
    expect_at(t + 6,  "glitch_a", 3'b000, 1'b1, 2'd2, 8'd1);
    expect_at(t + 10, "glitch_b", 3'b000, 1'b1, 2'd2, 8'd1);
    NRST = 1'b0;
    tick(3);
    NRST = 1'b1;
    wait_to(t + 12);

    // 3b. Long press: reassert at 2 + DB + 1, hold until released for DB cycles
    t = cyc;
    e = t + 18;
    expect_at(t + 6,      "btn_pre",     3'b000, 1'b1, 2'd2, 8'd1);
    expect_at(t + 7,      "btn_hit",     3'b111, 1'b0, 2'd1, 8'd1);
    expect_at(e - 1,      "btn_hold",    3'b111, 1'b0, 2'd1, 8'd1);
    expect_at(e + SD - 1, "btn_b0_pre",  3'b111, 1'b0, 2'd1, 8'd1);
    expect_at(e + SD,     "btn_b0",      3'b110, 1'b0, 2'd1, 8'd1);
    expect_at(e + 3*SD,   "btn_run",     3'b000, 1'b1, 2'd1, 8'd1);
    NRST = 1'b0;
    tick(10);
    NRST = 1'b1;
    wait_to(e + 3*SD + 3);

    // 4. Press and lock loss seen in the same cycle: button wins, loss still counted
    t = cyc;
    e = t + 20;
    expect_at(t + 6,      "sim_pre",    3'b000, 1'b1, 2'd1, 8'd1);
    expect_at(t + 7,      "sim_hit",    3'b111, 1'b0, 2'd1, 8'd2);
    expect_at(e - 1,      "sim_hold",   3'b111, 1'b0, 2'd1, 8'd2);
    expect_at(e + 3*SD-1, "sim_b2_pre", 3'b100, 1'b0, 2'd1, 8'd2);
    expect_at(e + 3*SD,   "sim_run",    3'b000, 1'b1, 2'd1, 8'd2);
    NRST = 1'b0;
    tick(DB);
    pll_lock = 1'b0;
    tick(1);
    pll_lock = 1'b1;
    wait_to(t + 12);
    NRST = 1'b1;
    wait_to(e + 3*SD + 3);

    // 5. Lock loss after stage 0 released: all stages back at once, full re-sequence
    t = cyc;
    e = t + 26;
    expect_at(t + 3,      "mid_first",   3'b111, 1'b0, 2'd2, 8'd3);
    expect_at(t + 15,     "mid_b0_pre",  3'b111, 1'b0, 2'd2, 8'd3);
    expect_at(t + 16,     "mid_b0",      3'b110, 1'b0, 2'd2, 8'd3);
    expect_at(t + 20,     "mid_pre",     3'b110, 1'b0, 2'd2, 8'd3);
    expect_at(t + 21,     "mid_hit",     3'b111, 1'b0, 2'd2, 8'd4);
    expect_at(e + SD - 1, "mid_rb0_pre", 3'b111, 1'b0, 2'd2, 8'd4);
    expect_at(e + SD,     "mid_rb0",     3'b110, 1'b0, 2'd2, 8'd4);
    expect_at(e + 3*SD,   "mid_run",     3'b000, 1'b1, 2'd2, 8'd4);
    pll_lock = 1'b0;
    tick(1);
    pll_lock = 1'b1;
    wait_to(t + 18);
    pll_lock = 1'b0;
    tick(1);
    pll_lock = 1'b1;
    wait_to(e + 3*SD + 3);

    // 6. 300 further lock losses, one every relock; counter saturates at 255
    for (int k = 1; k <= 300; k++) begin
      t = cyc;
      c = 4 + k;
      if (c > 255) c = 255;
      if (k == 1 || k == 100 || k == 250 || k == 251 || k == 252 || k == 300)
        expect_at(t + 3, $sformatf("sat_%0d", k), 3'b111, 1'b0, 2'd2, 8'(c));
      pll_lock = 1'b0;
      tick(1);
      pll_lock = 1'b1;
      wait_to(t + 8);
    end
    e = cyc;
    expect_at(e + 3*SD,     "sat_run",   3'b000, 1'b1, 2'd2, 8'd255);
    expect_at(e + 3*SD + 5, "sat_hold",  3'b000, 1'b1, 2'd2, 8'd255);
    expect_at(e + 3*SD + 6, "async_rst", 3'b111, 1'b0, 2'd0, 8'd0);
    wait_to(e + 3*SD + 6);
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(2);

    for (int i = 0; i < 50 && sb.size() != 0; i++) tick(1);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
